// File: rtl/saddc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : saddc_pkg
//  Description : Shared types and default widths for the decision-tree
//                traversal sequencer: FSM state encoding, node record
//                layout and width constants.
//  Macros      : none (PERF_CNT_EN is consumed by the top and interface)
//  Revision    : 1.0 - initial release
// ============================================================================
package saddc_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NODE_AW   = 8;
    localparam int DEF_FEAT_AW   = 5;
    localparam int DEF_MAX_DEPTH = 16;
    localparam int DEPTH_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_NODE  = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // One node-memory record at the default widths.
    typedef struct packed {
        logic                   is_leaf;
        logic [DEF_FEAT_AW-1:0] feature;
        logic [DEF_DATA_W-1:0]  threshold;
        logic [DEF_NODE_AW-1:0] left;
        logic [DEF_NODE_AW-1:0] right;
    } node_rec_t;

endpackage : saddc_pkg
`default_nettype wire

// File: rtl/tree_traversal_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tree_traversal_sequencer_if
//  Description : Bundles the host start/result handshake, node-memory and
//                feature-memory read ports and the ControlUnit operand path.
//                master = sequencer side, slave = host/memories/ControlUnit.
//  Macros      : PERF_CNT_EN adds io_perf_nodes / io_perf_trees
//  Revision    : 1.0 - initial release
// ============================================================================
interface tree_traversal_sequencer_if
    import saddc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NODE_AW = DEF_NODE_AW,
    parameter int FEAT_AW = DEF_FEAT_AW
);
    // host start
    logic               io_start_valid;
    logic               io_start_ready;
    logic [NODE_AW-1:0] io_root_addr;
    // node memory
    logic               io_node_rd_en;
    logic [NODE_AW-1:0] io_node_rd_addr;
    logic               io_node_is_leaf;
    logic [FEAT_AW-1:0] io_node_feature;
    logic [DATA_W-1:0]  io_node_threshold;
    logic [NODE_AW-1:0] io_node_left;
    logic [NODE_AW-1:0] io_node_right;
    // feature memory
    logic               io_feat_rd_en;
    logic [FEAT_AW-1:0] io_feat_rd_addr;
    logic [DATA_W-1:0]  io_feat_rd_data;
    // ControlUnit
    logic [DATA_W-1:0]  io_cmp_fBlock;
    logic [DATA_W-1:0]  io_cmp_wBlock;
    logic               io_cmp_decision;
    // host result
    logic               io_result_valid;
    logic               io_result_ready;
    logic [DATA_W-1:0]  io_result_class;
    logic [DEPTH_W-1:0] io_result_depth;
    logic               io_result_err;
`ifdef PERF_CNT_EN
    logic [31:0]        io_perf_nodes;
    logic [31:0]        io_perf_trees;
`endif

    modport master (
        input  io_start_valid, io_root_addr,
        output io_start_ready,
        output io_node_rd_en, io_node_rd_addr,
        input  io_node_is_leaf, io_node_feature, io_node_threshold,
               io_node_left, io_node_right,
        output io_feat_rd_en, io_feat_rd_addr,
        input  io_feat_rd_data,
        output io_cmp_fBlock, io_cmp_wBlock,
        input  io_cmp_decision,
        output io_result_valid, io_result_class, io_result_depth, io_result_err,
        input  io_result_ready
`ifdef PERF_CNT_EN
       ,output io_perf_nodes, io_perf_trees
`endif
    );

    modport slave (
        output io_start_valid, io_root_addr,
        input  io_start_ready,
        input  io_node_rd_en, io_node_rd_addr,
        output io_node_is_leaf, io_node_feature, io_node_threshold,
               io_node_left, io_node_right,
        input  io_feat_rd_en, io_feat_rd_addr,
        output io_feat_rd_data,
        input  io_cmp_fBlock, io_cmp_wBlock,
        output io_cmp_decision,
        input  io_result_valid, io_result_class, io_result_depth, io_result_err,
        output io_result_ready
`ifdef PERF_CNT_EN
       ,input  io_perf_nodes, io_perf_trees
`endif
    );

endinterface : tree_traversal_sequencer_if
`default_nettype wire

// File: rtl/saddc_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : saddc_perf_cnt
//  Description : Free-running 32-bit event counters for node fetches and
//                completed traversals. Wrap at 2^32, cleared only by reset.
//  Ports       : clk, reset (async, active-high)
//                i_node_fetch  - one node-memory read this cycle
//                i_tree_done   - result handshake this cycle
//                o_perf_nodes  - total node fetches
//                o_perf_trees  - total completed results
//  Revision    : 1.0 - initial release
// ============================================================================
module saddc_perf_cnt (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_node_fetch,
    input  wire logic        i_tree_done,
    output logic [31:0]      o_perf_nodes,
    output logic [31:0]      o_perf_trees
);
    logic [31:0] nodes_q, nodes_d;
    logic [31:0] trees_q, trees_d;

    always_comb begin
        nodes_d = nodes_q + 32'(i_node_fetch);
        trees_d = trees_q + 32'(i_tree_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nodes_q <= '0;
            trees_q <= '0;
        end else begin
            nodes_q <= nodes_d;
            trees_q <= trees_d;
        end
    end

    assign o_perf_nodes = nodes_q;
    assign o_perf_trees = trees_q;

endmodule : saddc_perf_cnt
`default_nettype wire

// File: rtl/tree_traversal_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tree_traversal_sequencer
//  Description : Walks one decision tree per start request. Fetches node
//                records, presents feature/threshold operands to the
//                ControlUnit, follows left/right children until a leaf and
//                holds the class label until the host consumes it. Walks
//                deeper than MAX_DEPTH internal nodes end with err=1.
//  Ports       : clk, reset (async, active-high)
//                bus  - tree_traversal_sequencer_if.master (start/result
//                       handshake, node/feature memory reads, comparator)
//  Macros      : PERF_CNT_EN - adds io_perf_nodes / io_perf_trees counters
//  Revision    : 1.0 - initial release
// ============================================================================
module tree_traversal_sequencer
    import saddc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NODE_AW   = DEF_NODE_AW,
    parameter int FEAT_AW   = DEF_FEAT_AW,
    parameter int MAX_DEPTH = DEF_MAX_DEPTH
) (
    input wire logic                    clk,
    input wire logic                    reset,
    tree_traversal_sequencer_if.master  bus
);
    localparam logic [DEPTH_W-1:0] c_max_depth = DEPTH_W'(MAX_DEPTH);

    state_t             state_q, state_d;
    logic [NODE_AW-1:0] addr_q, addr_d;         // doubles as io_node_rd_addr
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [DATA_W-1:0]  thr_q, thr_d;
    logic [NODE_AW-1:0] left_q, left_d;
    logic [NODE_AW-1:0] right_q, right_d;
    logic [FEAT_AW-1:0] feat_addr_q, feat_addr_d;
    logic [DATA_W-1:0]  class_q, class_d;
    logic               err_q, err_d;

    logic               w_start_ready;
    logic               w_node_rd_en;
    logic               w_feat_rd_en;
    logic               w_result_valid;
    logic [DATA_W-1:0]  w_fblock;
    logic [DATA_W-1:0]  w_wblock;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        depth_d        = depth_q;
        thr_d          = thr_q;
        left_d         = left_q;
        right_d        = right_q;
        feat_addr_d    = feat_addr_q;
        class_d        = class_q;
        err_d          = err_q;
        w_start_ready  = 1'b0;
        w_node_rd_en   = 1'b0;
        w_feat_rd_en   = 1'b0;
        w_result_valid = 1'b0;
        w_fblock       = '0;
        w_wblock       = '0;

        unique case (state_q)
            ST_IDLE: begin
                w_start_ready = 1'b1;
                if (bus.io_start_valid) begin
                    addr_d  = bus.io_root_addr;
                    depth_d = '0;
                    class_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_node_rd_en = 1'b1;
                state_d      = ST_NODE;
            end
            ST_NODE: begin
                if (bus.io_node_is_leaf) begin
                    class_d = bus.io_node_threshold;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (depth_q == c_max_depth) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    thr_d        = bus.io_node_threshold;
                    left_d       = bus.io_node_left;
                    right_d      = bus.io_node_right;
                    w_feat_rd_en = 1'b1;
                    feat_addr_d  = bus.io_node_feature;
                    state_d      = ST_CMP;
                end
            end
            ST_CMP: begin
                // Feature word arrives this cycle; decision is combinational.
                w_fblock = bus.io_feat_rd_data;
                w_wblock = thr_q;
                addr_d   = bus.io_cmp_decision ? right_q : left_q;
                depth_d  = (depth_q == c_max_depth) ? depth_q : depth_q + 1'b1;
                state_d  = ST_FETCH;
            end
            ST_DONE: begin
                w_result_valid = 1'b1;
                if (bus.io_result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            depth_q     <= '0;
            thr_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            feat_addr_q <= '0;
            class_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            depth_q     <= depth_d;
            thr_q       <= thr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            feat_addr_q <= feat_addr_d;
            class_q     <= class_d;
            err_q       <= err_d;
        end
    end

    // start_ready is gated by reset so it reads 0 while reset is held.
    assign bus.io_start_ready  = w_start_ready & ~reset;
    assign bus.io_node_rd_en   = w_node_rd_en;
    assign bus.io_node_rd_addr = addr_q;
    assign bus.io_feat_rd_en   = w_feat_rd_en;
    // Presents the new index during the strobe, then holds it afterwards.
    assign bus.io_feat_rd_addr = feat_addr_d;
    assign bus.io_cmp_fBlock   = w_fblock;
    assign bus.io_cmp_wBlock   = w_wblock;
    assign bus.io_result_valid = w_result_valid;
    assign bus.io_result_class = class_q;
    assign bus.io_result_depth = depth_q;
    assign bus.io_result_err   = err_q;

`ifdef PERF_CNT_EN
    logic [31:0] w_perf_nodes;
    logic [31:0] w_perf_trees;

    saddc_perf_cnt u_perf_cnt (
        .clk          (clk),
        .reset        (reset),
        .i_node_fetch (w_node_rd_en),
        .i_tree_done  (w_result_valid & bus.io_result_ready),
        .o_perf_nodes (w_perf_nodes),
        .o_perf_trees (w_perf_trees)
    );

    assign bus.io_perf_nodes = w_perf_nodes;
    assign bus.io_perf_trees = w_perf_trees;
`endif

endmodule : tree_traversal_sequencer
`default_nettype wire

// File: tb/tb_tree_traversal_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tree_traversal_sequencer
//  Description : Directed bench for tree_traversal_sequencer. Provides node
//                and feature memories with one-cycle read latency and a
//                ControlUnit stand-in (decision = fBlock > wBlock).
//  Macros      : PERF_CNT_EN - also checks the performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_traversal_sequencer;
    import saddc_pkg::*;

    logic clk;
    logic reset;

    tree_traversal_sequencer_if bus ();

    tree_traversal_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- models
    node_rec_t   node_mem [256];
    logic [31:0] feat_mem [32];
    node_rec_t   node_rd_q;
    logic [31:0] feat_rd_q;

    always @(posedge clk) begin
        if (bus.io_node_rd_en) node_rd_q <= node_mem[bus.io_node_rd_addr];
        if (bus.io_feat_rd_en) feat_rd_q <= feat_mem[bus.io_feat_rd_addr];
    end

    assign bus.io_node_is_leaf   = node_rd_q.is_leaf;
    assign bus.io_node_feature   = node_rd_q.feature;
    assign bus.io_node_threshold = node_rd_q.threshold;
    assign bus.io_node_left      = node_rd_q.left;
    assign bus.io_node_right     = node_rd_q.right;
    assign bus.io_feat_rd_data   = feat_rd_q;
    assign bus.io_cmp_decision   = (bus.io_cmp_fBlock > bus.io_cmp_wBlock);

    // ---------------------------------------------------------------- checks
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Handshake a start; returns with the clock #1 past the handshake edge.
    task automatic do_start(input logic [7:0] root);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.io_start_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("start_ready_seen", 64'(bus.io_start_ready), 64'd1);
        bus.io_root_addr   = root;
        bus.io_start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.io_start_valid = 1'b0;
    endtask

    // Runs one walk; cnt = cycles from handshake cycle to first result_valid.
    task automatic run_tree(input logic [7:0] root, output int cnt,
                            output logic [31:0] fblk, output logic [31:0] wblk,
                            output logic [7:0] naddr2, output logic [4:0] faddr);
        do_start(root);
        cnt = 1; fblk = '0; wblk = '0; naddr2 = '0; faddr = '0;
        while (!bus.io_result_valid && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 2) faddr  = bus.io_feat_rd_addr;
            if (cnt == 3) begin fblk = bus.io_cmp_fBlock; wblk = bus.io_cmp_wBlock; end
            if (cnt == 4) naddr2 = bus.io_node_rd_addr;
        end
    endtask

    task automatic consume();
        check_eq("start_ready_in_done", 64'(bus.io_start_ready), 64'd0);
        @(negedge clk);
        bus.io_result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.io_result_ready = 1'b0;
        check_eq("valid_after_consume", 64'(bus.io_result_valid), 64'd0);
        check_eq("ready_after_consume", 64'(bus.io_start_ready), 64'd1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int          cnt;
        logic [31:0] fb, wb;
        logic [7:0]  na;
        logic [4:0]  fa;

        for (int i = 0; i < 256; i++) node_mem[i] = '0;
        for (int i = 0; i < 32; i++)  feat_mem[i] = '0;
        node_mem[8'h00] = '{is_leaf: 1'b1, feature: 5'd0, threshold: 32'd7,   left: 8'h00, right: 8'h00};
        node_mem[8'h01] = '{is_leaf: 1'b0, feature: 5'd2, threshold: 32'd100, left: 8'h02, right: 8'h03};
        node_mem[8'h02] = '{is_leaf: 1'b1, feature: 5'd0, threshold: 32'd3,   left: 8'h00, right: 8'h00};
        node_mem[8'h03] = '{is_leaf: 1'b1, feature: 5'd0, threshold: 32'd9,   left: 8'h00, right: 8'h00};
        node_mem[8'h05] = '{is_leaf: 1'b0, feature: 5'd1, threshold: 32'd0,   left: 8'h05, right: 8'h05};
        feat_mem[1] = 32'd77;
        feat_mem[2] = 32'd50;
        node_rd_q = '0;
        feat_rd_q = '0;

        bus.io_start_valid  = 1'b0;
        bus.io_root_addr    = '0;
        bus.io_result_ready = 1'b0;
        reset = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_start_ready", 64'(bus.io_start_ready), 64'd0);
        check_eq("rst_outputs", {bus.io_result_valid, bus.io_node_rd_en, bus.io_feat_rd_en,
                                 bus.io_result_err, bus.io_result_depth, bus.io_node_rd_addr,
                                 bus.io_feat_rd_addr}, 64'd0);
        check_eq("rst_class", 64'(bus.io_result_class), 64'd0);
        check_eq("rst_fblock", 64'({bus.io_cmp_fBlock, bus.io_cmp_wBlock}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("idle_start_ready", 64'(bus.io_start_ready), 64'd1);

        // Scenario 1: root is a leaf
        run_tree(8'h00, cnt, fb, wb, na, fa);
        check_eq("s1_latency", 64'(cnt), 64'd3);
        check_eq("s1_class",   64'(bus.io_result_class), 64'd7);
        check_eq("s1_depth",   64'(bus.io_result_depth), 64'd0);
        check_eq("s1_err",     64'(bus.io_result_err),   64'd0);
        consume();

        // Scenario 2: 50 vs 100 -> left leaf
        run_tree(8'h01, cnt, fb, wb, na, fa);
        check_eq("s2_latency", 64'(cnt), 64'd6);
        check_eq("s2_feat_addr", 64'(fa), 64'd2);
        check_eq("s2_fblock", 64'(fb), 64'd50);
        check_eq("s2_wblock", 64'(wb), 64'd100);
        check_eq("s2_next_addr", 64'(na), 64'h02);
        check_eq("s2_class", 64'(bus.io_result_class), 64'd3);
        check_eq("s2_depth", 64'(bus.io_result_depth), 64'd1);
        check_eq("s2_err",   64'(bus.io_result_err),   64'd0);
        consume();

        // Scenario 3: 150 vs 100 -> right leaf
        feat_mem[2] = 32'd150;
        run_tree(8'h01, cnt, fb, wb, na, fa);
        check_eq("s3_latency", 64'(cnt), 64'd6);
        check_eq("s3_fblock", 64'(fb), 64'd150);
        check_eq("s3_next_addr", 64'(na), 64'h03);
        check_eq("s3_class", 64'(bus.io_result_class), 64'd9);
        check_eq("s3_depth", 64'(bus.io_result_depth), 64'd1);
        consume();

`ifdef PERF_CNT_EN
        check_eq("perf_nodes", 64'(bus.io_perf_nodes), 64'd5);
        check_eq("perf_trees", 64'(bus.io_perf_trees), 64'd3);
`endif

        // Self-loop hits the depth limit; result held while ready is low
        run_tree(8'h05, cnt, fb, wb, na, fa);
        check_eq("loop_latency", 64'(cnt), 64'd51);
        for (int i = 0; i < 10; i++) begin
            check_eq("loop_hold", {bus.io_result_valid, bus.io_start_ready, bus.io_result_err,
                                   bus.io_result_depth, bus.io_result_class},
                     {1'b1, 1'b0, 1'b1, 5'd16, 32'd0});
            @(posedge clk);
            #1;
        end
        consume();

        // Reset asserted during CMP aborts the walk
        feat_mem[2] = 32'd50;
        do_start(8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_rst_cmp_fblock", 64'(bus.io_cmp_fBlock), 64'd50);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_operands", 64'({bus.io_cmp_fBlock, bus.io_cmp_wBlock}), 64'd0);
        check_eq("midrst_ctrl", {bus.io_start_ready, bus.io_result_valid, bus.io_node_rd_en,
                                 bus.io_feat_rd_en, bus.io_node_rd_addr}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("no_result_after_rst", 64'(bus.io_result_valid), 64'd0);

        // Normal walk after reset release
        feat_mem[2] = 32'd150;
        run_tree(8'h01, cnt, fb, wb, na, fa);
        check_eq("post_rst_latency", 64'(cnt), 64'd6);
        check_eq("post_rst_class", 64'(bus.io_result_class), 64'd9);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tree_traversal_sequencer
`default_nettype wire
